// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack sequencer: opcode encodings,
// sequencer states and small opcode-classification helpers.
package stack_pkg;

    localparam logic [15:0] STACK_BASE_DEFAULT = 16'hFF00;
    localparam int          DEPTH_DEFAULT      = 16;

    localparam logic [5:0] OP_PUSH = 6'b000101;
    localparam logic [5:0] OP_POP  = 6'b000100;
    localparam logic [5:0] OP_CALL = 6'b000110;
    localparam logic [5:0] OP_RET  = 6'b000111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operations that write a word below the current stack pointer.
    function automatic logic is_push_op(input logic [5:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    // Operations that read the word at the current stack pointer.
    function automatic logic is_pop_op(input logic [5:0] op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Data-memory port of the stack sequencer: req/ack handshake with address,
// write data and read data. master = stack_ctrl, slave = memory.
interface stack_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// Hardware stack sequencer: guarded PUSH/POP/CALL/RET over a req/ack memory port.
// Optional STACK_CTRL_HWM_EN adds the hwm output (maximum depth since reset).
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_BASE = STACK_BASE_DEFAULT,
    parameter int          DEPTH      = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [5:0]                   opcode,
    input  logic [15:0]                  pc,
    input  logic [15:0]                  push_data,
    stack_ctrl_if.master                 mem,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  pop_data,
    output logic                         redirect,
    output logic [15:0]                  sp,
    output logic [$clog2(DEPTH+1)-1:0]   depth
`ifdef STACK_CTRL_HWM_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

    localparam int          DW       = $clog2(DEPTH + 1);
    localparam logic [15:0] SP_EMPTY = STACK_BASE + 16'(DEPTH);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    state_t         state_q, state_d;
    logic [5:0]     op_q, op_d;
    logic [15:0]    sp_q, sp_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [15:0]    pop_data_q, pop_data_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           redirect_q, redirect_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [15:0]    mem_addr_q, mem_addr_d;
    logic [15:0]    mem_wdata_q, mem_wdata_d;
    logic           op_ready_q, op_ready_d;

    logic           req_push;
    logic           req_pop;
    logic           req_fault;

    // Classify the incoming request; anything unrecognised is a fault too.
    assign req_push  = is_push_op(opcode);
    assign req_pop   = is_pop_op(opcode);
    assign req_fault = !(req_push || req_pop)
                     || (req_push && (depth_q == DEPTH_FULL))
                     || (req_pop  && (depth_q == '0));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        pop_data_d  = pop_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        redirect_d  = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d = opcode;
                    if (req_fault) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = MEM;
                        mem_req_d  = 1'b1;
                        mem_we_d   = req_push;
                        mem_addr_d = req_push ? (sp_q - 16'd1) : sp_q;
                        if (opcode == OP_PUSH)
                            mem_wdata_d = push_data;
                        else if (opcode == OP_CALL)
                            mem_wdata_d = pc + 16'd1;
                    end
                end
            end

            MEM: begin
                mem_req_d = mem_req_q;
                mem_we_d  = mem_we_q;
                if (mem.mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = RESP;
                    done_d     = 1'b1;
                    redirect_d = (op_q == OP_RET);
                    if (is_push_op(op_q)) begin
                        sp_d    = sp_q - 16'd1;
                        depth_d = depth_q + 1'b1;
                    end else begin
                        sp_d       = sp_q + 16'd1;
                        depth_d    = depth_q - 1'b1;
                        pop_data_d = mem.mem_rdata;
                    end
                end
            end

            RESP: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        op_ready_d = (state_d == IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sp_q        <= SP_EMPTY;
            depth_q     <= '0;
            pop_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            redirect_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            op_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            pop_data_q  <= pop_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            redirect_q  <= redirect_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            op_ready_q  <= op_ready_d;
        end
    end

`ifdef STACK_CTRL_HWM_EN
    logic [DW-1:0] hwm_q;

    // Tracks the next depth so the mark moves on the same edge as depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hwm_q <= '0;
        else if (depth_d > hwm_q)
            hwm_q <= depth_d;
    end

    assign hwm = hwm_q;
`endif

    assign op_ready      = op_ready_q;
    assign done          = done_q;
    assign err           = err_q;
    assign redirect      = redirect_q;
    assign pop_data      = pop_data_q;
    assign sp            = sp_q;
    assign depth         = depth_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed, scoreboard-checked bench for stack_ctrl; define STACK_CTRL_HWM_EN
// to also exercise the high-water-mark output.
module tb_stack_ctrl;
    import stack_pkg::*;

    typedef struct packed {
        logic        err;
        logic        redirect;
        logic [15:0] pop_data;
        logic [15:0] sp;
        logic [4:0]  depth;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  opcode;
    logic [15:0] pc;
    logic [15:0] push_data;
    logic        done;
    logic        err;
    logic [15:0] pop_data;
    logic        redirect;
    logic [15:0] sp;
    logic [4:0]  depth;
`ifdef STACK_CTRL_HWM_EN
    logic [4:0]  hwm;
`endif

    stack_ctrl_if mem_if ();

    stack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .pc        (pc),
        .push_data (push_data),
        .mem       (mem_if.master),
        .done      (done),
        .err       (err),
        .pop_data  (pop_data),
        .redirect  (redirect),
        .sp        (sp),
        .depth     (depth)
`ifdef STACK_CTRL_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [15:0] ram [16];   // memory as seen by the DUT
    logic [15:0] ref_mem [16];  // expected stack contents
    logic [15:0] m_sp;
    logic [4:0]  m_depth;
    logic [15:0] m_pop;
    logic [4:0]  m_hwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_sp    = 16'hFF10;
        m_depth = 5'd0;
        m_pop   = 16'h0000;
        m_hwm   = 5'd0;
        sb.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        check({tag, "_done"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"},      32'(err),      32'(e.err));
            check({tag, "_redirect"}, 32'(redirect), 32'(e.redirect));
            check({tag, "_pop_data"}, 32'(pop_data), 32'(e.pop_data));
            check({tag, "_sp"},       32'(sp),       32'(e.sp));
            check({tag, "_depth"},    32'(depth),    32'(e.depth));
        end
    endtask

    // One complete operation: model predicts the outcome, pushes it to the
    // scoreboard, then drives the request and answers memory after w waits.
    task automatic do_op(input string tag, input logic [5:0] opc,
                         input logic [15:0] pcv, input logic [15:0] dat, input int w);
        logic        is_push, is_pop, fault;
        logic [15:0] exp_addr, exp_wdata;
        exp_t        e;
        is_push = (opc == OP_PUSH) || (opc == OP_CALL);
        is_pop  = (opc == OP_POP)  || (opc == OP_RET);
        fault   = !(is_push || is_pop) || (is_push && m_depth == 5'd16)
                || (is_pop && m_depth == 5'd0);
        exp_addr  = 16'h0;
        exp_wdata = 16'h0;
        e.redirect = 1'b0;
        e.err      = fault;
        if (!fault && is_push) begin
            exp_addr  = m_sp - 16'd1;
            exp_wdata = (opc == OP_PUSH) ? dat : pcv + 16'd1;
            ref_mem[exp_addr[3:0]] = exp_wdata;
            m_sp    = m_sp - 16'd1;
            m_depth = m_depth + 5'd1;
        end else if (!fault) begin
            exp_addr   = m_sp;
            m_pop      = ref_mem[exp_addr[3:0]];
            m_sp       = m_sp + 16'd1;
            m_depth    = m_depth - 5'd1;
            e.redirect = (opc == OP_RET);
        end
        if (m_depth > m_hwm) m_hwm = m_depth;
        e.pop_data = m_pop;
        e.sp       = m_sp;
        e.depth    = m_depth;
        sb.push_back(e);

        @(negedge clk);
        check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        opcode    = opc;
        pc        = pcv;
        push_data = dat;
        op_valid  = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        if (fault) begin
            check({tag, "_no_req"}, 32'(mem_if.mem_req), 32'd0);
            check_done(tag);
        end else begin
            check({tag, "_req"}, 32'(mem_if.mem_req), 32'd1);
            check({tag, "_we"},  32'(mem_if.mem_we),  32'(is_push));
            check({tag, "_addr"}, 32'(mem_if.mem_addr), 32'(exp_addr));
            if (is_push) check({tag, "_wdata"}, 32'(mem_if.mem_wdata), 32'(exp_wdata));
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                check({tag, "_req_hold"},  32'(mem_if.mem_req),  32'd1);
                check({tag, "_addr_hold"}, 32'(mem_if.mem_addr), 32'(exp_addr));
                check({tag, "_no_early_done"}, 32'(done), 32'd0);
            end
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = ram[mem_if.mem_addr[3:0]];
            if (mem_if.mem_we) ram[mem_if.mem_addr[3:0]] = mem_if.mem_wdata;
            @(negedge clk);
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = 16'hDEAD;
            check({tag, "_req_drop"}, 32'(mem_if.mem_req), 32'd0);
            check_done(tag);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        op_valid         = 1'b0;
        opcode           = 6'd0;
        pc               = 16'd0;
        push_data        = 16'd0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 16'h0;
            ref_mem[i] = 16'h0;
        end
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_sp",       32'(sp),       32'hFF10);
        check("rst_depth",    32'(depth),    32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_mem_req",  32'(mem_if.mem_req),   32'd0);
        check("rst_mem_we",   32'(mem_if.mem_we),    32'd0);
        check("rst_mem_addr", 32'(mem_if.mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
        rst = 1'b0;

        // Basic PUSH / POP, CALL / RET with wait states
        do_op("push_abcd", OP_PUSH, 16'h0000, 16'hABCD, 0);
        do_op("pop_abcd",  OP_POP,  16'h0000, 16'h0000, 1);
        do_op("call",      OP_CALL, 16'h0041, 16'h0000, 2);
        do_op("ret",       OP_RET,  16'h0000, 16'h0000, 2);

        // Faults: underflow and illegal opcode
        do_op("pop_empty", OP_POP,  16'h0000, 16'h0000, 0);
        do_op("ret_empty", OP_RET,  16'h0000, 16'h0000, 0);
        do_op("illegal",   6'b111111, 16'h0000, 16'h0000, 0);

        // Stray ack while idle must be ignored
        @(negedge clk);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        check("stray_ack_sp",   32'(sp),   32'hFF10);
        check("stray_ack_done", 32'(done), 32'd0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 16; i++)
            do_op("fill", OP_PUSH, 16'h0000, 16'h1000 + 16'(i), i % 3);
        do_op("overflow", OP_PUSH, 16'h0000, 16'h5555, 0);
        do_op("call_full", OP_CALL, 16'h1234, 16'h0000, 0);
`ifdef STACK_CTRL_HWM_EN
        check("hwm_full", 32'(hwm), 32'd16);
`endif
        do_op("pop_top",  OP_POP, 16'h0000, 16'h0000, 0);
        do_op("pop_next", OP_POP, 16'h0000, 16'h0000, 1);

        // Reset while MEM with ack withheld
        @(negedge clk);
        opcode    = OP_PUSH;
        push_data = 16'h7777;
        op_valid  = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("abort_req_up", 32'(mem_if.mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_req_drop", 32'(mem_if.mem_req), 32'd0);
        check("abort_sp",       32'(sp),    32'hFF10);
        check("abort_depth",    32'(depth), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_op("post_abort_push", OP_PUSH, 16'h0000, 16'h2468, 0);

`ifdef STACK_CTRL_HWM_EN
        apply_reset();
        check("hwm_rst", 32'(hwm), 32'd0);
        do_op("hwm_p1", OP_PUSH, 16'h0000, 16'h0001, 0);
        do_op("hwm_p2", OP_PUSH, 16'h0000, 16'h0002, 1);
        do_op("hwm_p3", OP_PUSH, 16'h0000, 16'h0003, 0);
        do_op("hwm_o1", OP_POP,  16'h0000, 16'h0000, 0);
        do_op("hwm_o2", OP_POP,  16'h0000, 16'h0000, 2);
        do_op("hwm_p4", OP_PUSH, 16'h0000, 16'h0004, 0);
        check("hwm_value", 32'(hwm), 32'(m_hwm));
        check("hwm_three", 32'(hwm), 32'd3);
        check("hwm_depth", 32'(depth), 32'd2);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
